// File: rtl/regfile_pkg.sv
// Shared sizing constants and types for the register file.
// The optional x0 behaviour is selected with the REGFILE_ZERO_REG_EN macro.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEPTH      = 2 ** DEF_ADDR_W;

    typedef logic [DEF_DATA_W-1:0] word_t;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG_EN = 1'b1;
`else
    localparam bit ZERO_REG_EN = 1'b0;
`endif

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: a DEPTH:1 mux over the register array.
// Under REGFILE_ZERO_REG_EN, address 0 always reads as zero.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = regs[addr];
        if (ZERO_REG_EN && (addr == '0)) begin
            data = '0;
        end
    end

endmodule

// File: rtl/register_file.sv
// General-purpose register file: one synchronous write port, two combinational read ports.
// With REGFILE_ZERO_REG_EN defined, register 0 has no storage and reads as zero.
module register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              LD,
    input  logic [ADDR_W-1:0] SA,
    input  logic [ADDR_W-1:0] SB,
    input  logic [ADDR_W-1:0] DR,
    input  logic [DATA_W-1:0] D_IN,
    output logic [DATA_W-1:0] DATA_A,
    output logic [DATA_W-1:0] DATA_B
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];

    // Flop-based storage: every word must clear asynchronously, which rules out block RAM.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (ZERO_REG_EN && (gi == 0)) begin : g_zero
                assign regs[gi] = '0;
            end else begin : g_store
                logic [DATA_W-1:0] word_reg;
                logic              we;

                assign we = LD && (DR == ADDR_W'(gi));

                always_ff @(posedge CLK or negedge RST_N) begin
                    if (!RST_N) begin
                        word_reg <= '0;
                    end else if (we) begin
                        word_reg <= D_IN;
                    end
                end

                assign regs[gi] = word_reg;
            end
        end
    endgenerate

    regfile_read_port #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_port_a (
        .regs(regs),
        .addr(SA),
        .data(DATA_A)
    );

    regfile_read_port #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_port_b (
        .regs(regs),
        .addr(SB),
        .data(DATA_B)
    );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected read data,
// a negedge monitor pops and compares against DATA_A/DATA_B.
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic        ld;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [4:0]  dr;
    logic [31:0] d_in;
    logic [31:0] data_a;
    logic [31:0] data_b;

    typedef struct {
        string       tag;
        logic [31:0] ea;
        logic [31:0] eb;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    register_file dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .LD    (ld),
        .SA    (sa),
        .SB    (sb),
        .DR    (dr),
        .D_IN  (d_in),
        .DATA_A(data_a),
        .DATA_B(data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: sample on the falling edge, away from the write edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (data_a !== e.ea || data_b !== e.eb) begin
                errors++;
                $display("FAIL %s: got a=%h b=%h, expected a=%h b=%h", e.tag, data_a, data_b, e.ea, e.eb);
            end else begin
                $display("ok   %s: a=%h b=%h", e.tag, data_a, data_b);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Model of reading an address: x0 reads zero when the feature is built in.
    function automatic logic [31:0] rd(input int addr, input logic [31:0] stored);
`ifdef REGFILE_ZERO_REG_EN
        if (addr == 0) return 32'h0;
`endif
        return stored;
    endfunction

    task automatic wr(input logic [4:0] addr, input logic [31:0] val);
        ld   = 1'b1;
        dr   = addr;
        d_in = val;
        @(posedge clk);
        #1;
        ld   = 1'b0;
    endtask

    // Drive read addresses, queue expectation, and wait for the monitor's sample.
    task automatic chk(input logic [4:0] a, input logic [4:0] b,
                       input logic [31:0] ea, input logic [31:0] eb, input string tag);
        exp_t e;
        sa = a;
        sb = b;
        e.tag = tag;
        e.ea  = ea;
        e.eb  = eb;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        ld    = 1'b0;
        sa    = '0;
        sb    = '0;
        dr    = '0;
        d_in  = '0;
        #1 rst_n = 1'b0;

        // Reset state, and writes blocked during reset.
        chk(5'd0, 5'd31, 32'h0, 32'h0, "reset_state");
        wr(5'd4, 32'h77);
        chk(5'd4, 5'd4, 32'h0, 32'h0, "write_blocked_in_reset");

        // Reset release in the same cycle as LD: write lands on the next edge.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ld    = 1'b1;
        dr    = 5'd4;
        d_in  = 32'h77;
        chk(5'd4, 5'd4, 32'h0, 32'h0, "release_before_edge");
        @(posedge clk);
        #1;
        ld = 1'b0;
        chk(5'd4, 5'd0, 32'h77, 32'h0, "release_write_lands");

        // Asynchronous reset mid-cycle clears immediately.
        wr(5'd5, 32'hDEADBEEF);
        chk(5'd5, 5'd4, 32'hDEADBEEF, 32'h77, "pre_async_reset");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        chk(5'd5, 5'd4, 32'h0, 32'h0, "async_reset_no_edge");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic write to address 0.
        wr(5'd0, 32'd123);
        chk(5'd0, 5'd1, rd(0, 32'd123), 32'h0, "write_reg0");

        // LD=0 leaves the register untouched.
        ld   = 1'b0;
        dr   = 5'd3;
        d_in = 32'h55;
        @(posedge clk);
        #1;
        chk(5'd3, 5'd3, 32'h0, 32'h0, "ld_low_no_write");

        // Full sweep with crossing read addresses.
        for (int i = 0; i < 32; i++) begin
            wr(5'(i), 32'(i) * 32'h01010101);
        end
        for (int i = 0; i < 32; i++) begin
            chk(5'(i), 5'(31 - i), rd(i, 32'(i) * 32'h01010101),
                rd(31 - i, 32'(31 - i) * 32'h01010101), $sformatf("sweep_%0d", i));
        end
        chk(5'd17, 5'd17, 32'h11111111, 32'h11111111, "same_addr_both_ports");

        // Read during write: old value before the edge, new value after.
        wr(5'd7, 32'd10);
        ld   = 1'b1;
        dr   = 5'd7;
        d_in = 32'd20;
        chk(5'd7, 5'd6, 32'd10, 32'h06060606, "rdw_before_edge");
        @(posedge clk);
        #1;
        ld = 1'b0;
        chk(5'd7, 5'd7, 32'd20, 32'd20, "rdw_after_edge");

        // Back-to-back writes to the same register.
        wr(5'd2, 32'hA);
        wr(5'd2, 32'hB);
        chk(5'd2, 5'd2, 32'hB, 32'hB, "back_to_back_last_wins");
        chk(5'd1, 5'd3, 32'h01010101, 32'h03030303, "back_to_back_neighbours");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
